// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports with write-through
// bypass, NWR synchronous write ports, a hardwired zero register and an init sweep.
module regfile_mp #(
  parameter  int W        = 64,
  parameter  int DEPTH    = 32,
  parameter  int NRD      = 2,
  parameter  int NWR      = 2,
  parameter  int ZERO_REG = 31,
  parameter  int INIT_IDX = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              busy,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  input  logic [NWR*W-1:0]  wd,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*W-1:0]  rd
);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  localparam logic [AW-1:0] ZR       = AW'(ZERO_REG);
  localparam logic [AW:0]   ICNT_TOP = (AW+1)'(DEPTH - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW:0]     r_icnt;
  logic [AW:0]     w_icnt_nxt;
  logic [W-1:0]    r_mem [DEPTH];
  logic            w_init_we;
  logic [AW-1:0]   w_init_idx;
  logic [W-1:0]    w_init_val;
  logic [NRD*W-1:0] w_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_icnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_icnt  <= w_icnt_nxt;
    end
  end

  // NOTE: every variable driven here gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_icnt_nxt  = r_icnt;
    w_init_idx  = r_icnt[AW-1:0];
    w_init_we   = 1'b0;
    w_init_val  = (INIT_IDX != 0) ? W'(r_icnt[AW-1:0]) : '0;
    case (r_state)
      ST_INIT: begin
        w_init_we = (r_icnt[AW-1:0] != ZR);
        if (clear) begin
          w_icnt_nxt = '0;
        end else if (r_icnt == ICNT_TOP) begin
          w_state_nxt = ST_READY;
        end else begin
          w_icnt_nxt = r_icnt + (AW+1)'(1);
        end
      end
      ST_READY: begin
        if (clear) begin
          w_state_nxt = ST_INIT;
          w_icnt_nxt  = '0;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // NOTE: the array is deliberately left out of the reset; the init sweep
  // gives it defined contents, and skipping the reset lets it map onto RAM.
  // Later ports are assigned last, so the highest-numbered port wins a clash.
  always_ff @(posedge clk) begin
    if (w_init_we) begin
      r_mem[w_init_idx] <= w_init_val;
    end else if (r_state == ST_READY) begin
      for (int p = 0; p < NWR; p++) begin
        if (we[p] && (wa[p*AW +: AW] != ZR)) begin
          r_mem[wa[p*AW +: AW]] <= wd[p*W +: W];
        end
      end
    end
  end

  always_comb begin
    w_rd = '0;
    for (int r = 0; r < NRD; r++) begin
      if ((r_state == ST_READY) && (ra[r*AW +: AW] != ZR)) begin
        w_rd[r*W +: W] = r_mem[ra[r*AW +: AW]];
        for (int p = 0; p < NWR; p++) begin
          if (we[p] && (wa[p*AW +: AW] != ZR) && (wa[p*AW +: AW] == ra[r*AW +: AW])) begin
            w_rd[r*W +: W] = wd[p*W +: W];
          end
        end
      end
    end
  end

  assign rd   = w_rd;
  assign busy = (r_state == ST_INIT);

endmodule
